cfg_register_bank: RTL and testbench
====================================

Name: cfg_register_bank

Overview:
- Parametrised successor to the system configuration register file. Sits between the system controller (bus side) and the datapath blocks (UART, clock divider, ALU).
- Adds per-register reset values, a read-only mask and a hardware status-update port.
- Flags illegal accesses and emits per-register change pulses for the exported registers.

Parameters:
- ADDR_WIDTH, 4, address bus width.
- DATA_WIDTH, 8, register width.
- NUM_REGS, 16, implemented registers. Must satisfy 1 <= NUM_REGS <= 2**ADDR_WIDTH.
- NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 driven onto REG_OUT. Must satisfy NUM_EXPORT <= NUM_REGS.
- RST_VALUES, NUM_REGS*DATA_WIDTH bits, reset value of reg i at [i*DATA_WIDTH +: DATA_WIDTH]. Default: reg2=0x81 (prescale 32, parity enabled), reg3=0x20 (divide ratio 32), all others 0.
- RO_MASK, NUM_REGS bits, bit i=1 makes reg i read-only from the bus. Default 0.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- Address  in  ADDR_WIDTH  bus address.
- WrEn  in  1  bus write request.
- RdEn  in  1  bus read request.
- WrData  in  DATA_WIDTH  bus write data.
- HW_WrEn  in  1  hardware status write.
- HW_Addr  in  ADDR_WIDTH  hardware write address.
- HW_WrData  in  DATA_WIDTH  hardware write data.
- RdData  out  DATA_WIDTH  read data.
- RdData_Valid  out  1  one-cycle read-valid pulse.
- Access_Err  out  1  one-cycle illegal-access pulse.
- REG_OUT  out  NUM_EXPORT*DATA_WIDTH  flat export; reg i at [i*DATA_WIDTH +: DATA_WIDTH].
- Change_Pulse  out  NUM_EXPORT  bit i pulses when reg i changes value.

Behaviour:
- Reset: RST=1 at a clock edge loads every reg from RST_VALUES and clears RdData, RdData_Valid, Access_Err and Change_Pulse to 0.
  - Reset has priority over all requests, including ones in flight.
  - No Change_Pulse fires on reset.
- REG_OUT is combinational from the register array, so it shows new values right after the updating edge.
- Bus read: RdEn=1, WrEn=0, Address<NUM_REGS.
  - After the edge: RdData = pre-edge value of reg[Address], RdData_Valid=1 for exactly one cycle.
  - Latency is 1 cycle.
  - A same-cycle HW write to that address is not reflected in the read.
- RdData holds its last value while RdData_Valid=0.
- Bus write: WrEn=1, RdEn=0, Address<NUM_REGS, RO_MASK[Address]=0. reg[Address] <= WrData; visible on the next cycle.
- Errors: Access_Err=1 for one cycle after the edge, with no register change, when any of these hold:
  - WrEn=1 and RdEn=1 together: no operation, RdData_Valid stays 0.
  - Read with Address>=NUM_REGS: RdData=0, RdData_Valid=1.
  - Write with Address>=NUM_REGS: write dropped.
  - Write to a register with RO_MASK=1: write dropped.
- HW write: HW_WrEn=1, HW_Addr<NUM_REGS.
  - reg[HW_Addr] <= HW_WrData, ignoring RO_MASK.
  - HW_Addr>=NUM_REGS is silently ignored (no error).
- Collision: HW write and legal bus write to the same address in the same cycle. HW data wins, the bus write is dropped, and Access_Err pulses.
  - Different addresses: both commit in the same cycle.
- Change_Pulse[i]: registered, asserted in the cycle after the edge that commits a write to reg i with data != old value.
  - Aligned with the new REG_OUT value.
  - A write of an identical value gives no pulse.
- Back-to-back requests every cycle are supported; there are no stalls.
- All outputs are registered except REG_OUT.

Test Plan:
- Reset: assert RST for 1 cycle with WrEn=1 pending.
  - REG_OUT reg2=0x81, reg3=0x20, reg0=reg1=0x00.
  - No write committed; RdData=0, Access_Err=0, Change_Pulse=0.
- Read latency: write 0x5A to addr 5, then read addr 5.
  - RdData=0x5A with RdData_Valid=1 exactly one cycle after the read edge, then 0 the following cycle.
- Read-only: RO_MASK bit 1 set; bus writes 0xFF to addr 1 → reg1 unchanged, Access_Err pulses 1 cycle. HW write of 0x33 to addr 1 → reg1=0x33, Change_Pulse[1] pulses.
- Illegal accesses:
  - With NUM_REGS=12: read addr 13 → RdData=0x00, RdData_Valid=1, Access_Err=1.
  - WrEn=RdEn=1 at addr 0 → no change, RdData_Valid=0, Access_Err=1.
- Collision: bus writes 0x11 and HW writes 0x22 to addr 3 in the same cycle → reg3=0x22, Access_Err=1, Change_Pulse[3]=1. Rewrite 0x22 → no pulse.
- Reset mid-operation: RST asserted in the same cycle as a read of addr 2 → RdData_Valid stays 0 and reg2 returns to 0x81.

Source files
------------

// File: rtl/cfg_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : cfg_register_bank
// Description : Parametrised configuration register file with bus and
//               hardware write ports, read-only mask and change pulses.
// Revision    : 1.0
// ============================================================================
module cfg_register_bank #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int NUM_EXPORT = 4,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VALUES =
        (NUM_REGS*DATA_WIDTH)'(32'h2081_0000),
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [ADDR_WIDTH-1:0]          Address,
    input  logic                           WrEn,
    input  logic                           RdEn,
    input  logic [DATA_WIDTH-1:0]          WrData,
    input  logic                           HW_WrEn,
    input  logic [ADDR_WIDTH-1:0]          HW_Addr,
    input  logic [DATA_WIDTH-1:0]          HW_WrData,
    output logic [DATA_WIDTH-1:0]          RdData,
    output logic                           RdData_Valid,
    output logic                           Access_Err,
    output logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_OUT,
    output logic [NUM_EXPORT-1:0]          Change_Pulse
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_next [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_err;
    logic [NUM_EXPORT-1:0] r_change;

    logic [NUM_REGS-1:0]   w_bus_sel;
    logic [NUM_REGS-1:0]   w_hw_sel;
    logic [NUM_REGS-1:0]   w_hw_hit;
    logic [NUM_REGS-1:0]   w_bus_wr_hit;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_bus_in_range;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rd_value;

    // One-hot address decode; out-of-range addresses select nothing.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign w_bus_sel[gi] = (Address == ADDR_WIDTH'(gi));
            assign w_hw_sel[gi]  = (HW_Addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    assign w_rd_req       = RdEn & ~WrEn;
    assign w_wr_req       = WrEn & ~RdEn;
    assign w_bus_in_range = |w_bus_sel;
    assign w_hw_hit       = {NUM_REGS{HW_WrEn}} & w_hw_sel;
    // Hardware status updates win over a bus write to the same register.
    assign w_bus_wr_hit   = {NUM_REGS{w_wr_req}} & w_bus_sel & ~RO_MASK & ~w_hw_hit;

    assign w_err = (WrEn & RdEn)
                 | ((w_rd_req | w_wr_req) & ~w_bus_in_range)
                 | (w_wr_req & (|(w_bus_sel & RO_MASK)))
                 | (w_wr_req & (|(w_bus_sel & ~RO_MASK & w_hw_hit)));

    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_bus_sel[i]) w_rd_value = r_regs[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_next[i] = r_regs[i];
            if (w_hw_hit[i])
                w_next[i] = HW_WrData;
            else if (w_bus_wr_hit[i])
                w_next[i] = WrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= RST_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_change   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= w_next[i];
            r_rd_valid <= w_rd_req;
            if (w_rd_req)
                r_rd_data <= w_rd_value;
            r_err <= w_err;
            for (int i = 0; i < NUM_EXPORT; i++)
                r_change[i] <= (w_next[i] != r_regs[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_EXPORT; gi++) begin : g_export
            assign REG_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    assign RdData       = r_rd_data;
    assign RdData_Valid = r_rd_valid;
    assign Access_Err   = r_err;
    assign Change_Pulse = r_change;

endmodule
`default_nettype wire

// File: tb/tb_cfg_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_register_bank
// Description : Directed and randomized self-checking bench for the bank.
// Revision    : 1.0
// ============================================================================
module tb_cfg_register_bank;

    localparam int c_NREG = 12;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  Address = '0;
    logic        WrEn = 1'b0;
    logic        RdEn = 1'b0;
    logic [7:0]  WrData = '0;
    logic        HW_WrEn = 1'b0;
    logic [3:0]  HW_Addr = '0;
    logic [7:0]  HW_WrData = '0;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic        Access_Err;
    logic [31:0] REG_OUT;
    logic [3:0]  Change_Pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_regs [c_NREG];
    logic [7:0] m_old  [c_NREG];
    logic [7:0] exp_rd = 8'h00;
    logic       exp_v, exp_err;
    logic [3:0] exp_chg;

    cfg_register_bank #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .NUM_REGS   (c_NREG),
        .NUM_EXPORT (4),
        .RO_MASK    (12'h002)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .HW_WrEn      (HW_WrEn),
        .HW_Addr      (HW_Addr),
        .HW_WrData    (HW_WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .Access_Err   (Access_Err),
        .REG_OUT      (REG_OUT),
        .Change_Pulse (Change_Pulse)
    );

    always #5 CLK = ~CLK;

    // Applies the spec rules for one edge to the model.
    task automatic model_step();
        if (RST) begin
            for (int i = 0; i < c_NREG; i++)
                m_regs[i] = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
            exp_rd = 8'h00; exp_v = 1'b0; exp_err = 1'b0; exp_chg = 4'h0;
            return;
        end
        m_old   = m_regs;
        exp_v   = 1'b0;
        exp_err = 1'b0;
        if (WrEn && RdEn) begin
            exp_err = 1'b1;
        end else if (RdEn) begin
            exp_v = 1'b1;
            if (Address < c_NREG) exp_rd = m_old[Address];
            else begin exp_rd = 8'h00; exp_err = 1'b1; end
        end else if (WrEn) begin
            if (Address >= c_NREG || Address == 4'd1) exp_err = 1'b1;
            else if (HW_WrEn && HW_Addr == Address) exp_err = 1'b1;
            else m_regs[Address] = WrData;
        end
        if (HW_WrEn && HW_Addr < c_NREG) m_regs[HW_Addr] = HW_WrData;
        for (int i = 0; i < 4; i++) exp_chg[i] = (m_regs[i] != m_old[i]);
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; WrEn = 0; RdEn = 0; HW_WrEn = 0;
    endtask

    task automatic test_reset();
        RST = 1; WrEn = 1; Address = 4'd0; WrData = 8'hAA;
        tick();
        n_cmp++;
        if (REG_OUT !== 32'h2081_0000) begin
            n_fail++; $display("FAIL reset_regout got=%h exp=%h", REG_OUT, 32'h2081_0000);
        end
        n_cmp++;
        if ({RdData, RdData_Valid, Access_Err, Change_Pulse} !== 14'h0) begin
            n_fail++; $display("FAIL reset_outputs got rd=%h v=%b err=%b chg=%b exp all 0",
                               RdData, RdData_Valid, Access_Err, Change_Pulse);
        end
        idle();
    endtask

    task automatic test_read_latency();
        WrEn = 1; Address = 4'd5; WrData = 8'h5A;
        tick();
        idle(); RdEn = 1; Address = 4'd5;
        tick();
        n_cmp++;
        if (RdData !== 8'h5A || RdData_Valid !== 1'b1) begin
            n_fail++; $display("FAIL read_latency got rd=%h v=%b exp rd=5a v=1", RdData, RdData_Valid);
        end
        idle();
        tick();
        n_cmp++;
        if (RdData_Valid !== 1'b0 || RdData !== 8'h5A) begin
            n_fail++; $display("FAIL read_valid_drop got rd=%h v=%b exp rd=5a v=0", RdData, RdData_Valid);
        end
    endtask

    task automatic test_read_only();
        WrEn = 1; Address = 4'd1; WrData = 8'hFF;
        tick();
        n_cmp++;
        if (REG_OUT[15:8] !== 8'h00 || Access_Err !== 1'b1) begin
            n_fail++; $display("FAIL ro_bus_write got reg1=%h err=%b exp reg1=00 err=1", REG_OUT[15:8], Access_Err);
        end
        idle();
        tick();
        n_cmp++;
        if (Access_Err !== 1'b0) begin
            n_fail++; $display("FAIL ro_err_pulse got err=%b exp 0", Access_Err);
        end
        HW_WrEn = 1; HW_Addr = 4'd1; HW_WrData = 8'h33;
        tick();
        n_cmp++;
        if (REG_OUT[15:8] !== 8'h33 || Change_Pulse !== 4'b0010 || Access_Err !== 1'b0) begin
            n_fail++; $display("FAIL ro_hw_write got reg1=%h chg=%b err=%b exp reg1=33 chg=0010 err=0",
                               REG_OUT[15:8], Change_Pulse, Access_Err);
        end
        idle();
    endtask

    task automatic test_illegal();
        RdEn = 1; Address = 4'd13;
        tick();
        n_cmp++;
        if (RdData !== 8'h00 || RdData_Valid !== 1'b1 || Access_Err !== 1'b1) begin
            n_fail++; $display("FAIL oob_read got rd=%h v=%b err=%b exp rd=00 v=1 err=1",
                               RdData, RdData_Valid, Access_Err);
        end
        WrEn = 1; RdEn = 1; Address = 4'd0; WrData = 8'h77;
        tick();
        n_cmp++;
        if (REG_OUT[7:0] !== 8'h00 || RdData_Valid !== 1'b0 || Access_Err !== 1'b1) begin
            n_fail++; $display("FAIL rd_wr_both got reg0=%h v=%b err=%b exp reg0=00 v=0 err=1",
                               REG_OUT[7:0], RdData_Valid, Access_Err);
        end
        idle();
    endtask

    task automatic test_collision();
        WrEn = 1; Address = 4'd3; WrData = 8'h11;
        HW_WrEn = 1; HW_Addr = 4'd3; HW_WrData = 8'h22;
        tick();
        n_cmp++;
        if (REG_OUT[31:24] !== 8'h22 || Access_Err !== 1'b1 || Change_Pulse !== 4'b1000) begin
            n_fail++; $display("FAIL collision got reg3=%h err=%b chg=%b exp reg3=22 err=1 chg=1000",
                               REG_OUT[31:24], Access_Err, Change_Pulse);
        end
        idle(); WrEn = 1; Address = 4'd3; WrData = 8'h22;
        tick();
        n_cmp++;
        if (REG_OUT[31:24] !== 8'h22 || Change_Pulse !== 4'b0000 || Access_Err !== 1'b0) begin
            n_fail++; $display("FAIL same_value got reg3=%h chg=%b err=%b exp reg3=22 chg=0000 err=0",
                               REG_OUT[31:24], Change_Pulse, Access_Err);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        WrEn = 1; Address = 4'd2; WrData = 8'h44;
        tick();
        n_cmp++;
        if (REG_OUT[23:16] !== 8'h44 || Change_Pulse !== 4'b0100) begin
            n_fail++; $display("FAIL pre_reset_write got reg2=%h chg=%b exp reg2=44 chg=0100",
                               REG_OUT[23:16], Change_Pulse);
        end
        idle(); RST = 1; RdEn = 1; Address = 4'd2;
        tick();
        n_cmp++;
        if (RdData_Valid !== 1'b0 || REG_OUT[23:16] !== 8'h81 || Change_Pulse !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid got v=%b reg2=%h chg=%b exp v=0 reg2=81 chg=0000",
                               RdData_Valid, REG_OUT[23:16], Change_Pulse);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RST       = ($urandom_range(0, 49) == 0);
            WrEn      = $urandom_range(0, 1) == 1;
            RdEn      = $urandom_range(0, 2) == 0;
            Address   = 4'($urandom_range(0, 15));
            WrData    = 8'($urandom);
            HW_WrEn   = $urandom_range(0, 2) == 0;
            HW_Addr   = ($urandom_range(0, 1) == 1) ? Address : 4'($urandom_range(0, 15));
            HW_WrData = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick();
            n_cmp++;
            if (RdData !== exp_rd || RdData_Valid !== exp_v) begin
                n_fail++; $display("FAIL rand_read[%0d] got rd=%h v=%b exp rd=%h v=%b",
                                   n, RdData, RdData_Valid, exp_rd, exp_v);
            end
            n_cmp++;
            if (Access_Err !== exp_err) begin
                n_fail++; $display("FAIL rand_err[%0d] got %b exp %b", n, Access_Err, exp_err);
            end
            n_cmp++;
            if (Change_Pulse !== exp_chg) begin
                n_fail++; $display("FAIL rand_chg[%0d] got %b exp %b", n, Change_Pulse, exp_chg);
            end
            n_cmp++;
            if (REG_OUT !== {m_regs[3], m_regs[2], m_regs[1], m_regs[0]}) begin
                n_fail++; $display("FAIL rand_regout[%0d] got %h exp %h", n, REG_OUT,
                                   {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            end
        end
        idle();
    endtask

    initial begin
        #2;
        test_reset();
        test_read_latency();
        test_read_only();
        test_illegal();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
